// File: rtl/imem_loader.sv
// Instruction memory loader: takes a length header plus instruction bytes from a byte
// stream, writes imem from address 0 and holds the CPU meanwhile. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int Nloc    = 512,
    parameter int Dbits   = 32,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   imem_we,
    output logic [$clog2(Nloc)-1:0] imem_waddr,
    output logic [Dbits-1:0]       imem_wdata,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [$clog2(Nloc):0]  words_loaded
);

    localparam int AW  = $clog2(Nloc);
    localparam int BPW = Dbits / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t           state, state_next;
    logic [BCW-1:0]   bytecnt;
    logic [Dbits-1:0] shreg;
    logic [AW:0]      len;
    logic [TW-1:0]    tocnt;
    logic             we_q;
    logic             accept;
    logic             last_byte;
    logic             timeout_hit;
    logic             last_word;
    logic [Dbits-1:0] word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [Dbits-1:0] acc;
`endif

    assign accept      = rx_valid && rx_ready;
    assign last_byte   = (bytecnt == BCW'(BPW - 1));
    assign word_next   = (shreg << 8) | Dbits'(rx_data);
    assign last_word   = ((words_loaded + (AW + 1)'(1)) == len);
    assign timeout_hit = (TIMEOUT != 0) && !accept && (tocnt == TW'(TIMEOUT - 1));

    // A word completed on the previous edge must not reach memory if reset is being applied now.
    assign imem_we = we_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load_start) state_next = HDR;
            end
            ERR: begin
                cpu_hold = 1'b1;
                if (load_start) state_next = HDR;
            end
            HDR: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (timeout_hit) begin
                    state_next = ERR;
                end else if (accept && last_byte) begin
                    if (word_next == '0 || word_next > Dbits'(Nloc)) state_next = ERR;
                    else                                            state_next = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (timeout_hit) begin
                    state_next = ERR;
                end else if (accept && last_byte && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CSUM;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (timeout_hit) begin
                    state_next = ERR;
                end else if (accept && last_byte) begin
                    state_next = (word_next == acc) ? DONE : ERR;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Byte assembly, write-port registers, sticky flags and the idle-cycle watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            bytecnt      <= '0;
            shreg        <= '0;
            len          <= '0;
            tocnt        <= '0;
            we_q         <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc          <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (!busy && load_start) begin
                bytecnt      <= '0;
                shreg        <= '0;
                tocnt        <= '0;
                words_loaded <= '0;
                done         <= 1'b0;
                error        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                acc          <= '0;
`endif
            end else if (busy) begin
                tocnt <= accept ? '0 : tocnt + TW'(1);
                if (accept) begin
                    shreg   <= word_next;
                    bytecnt <= last_byte ? '0 : bytecnt + BCW'(1);
                    if (state == HDR && last_byte) begin
                        len <= (AW + 1)'(word_next);
                    end
                    if (state == DATA && last_byte) begin
                        we_q         <= 1'b1;
                        imem_wdata   <= word_next;
                        imem_waddr   <= words_loaded[AW-1:0];
                        words_loaded <= words_loaded + (AW + 1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        acc          <= acc + word_next;
`endif
                    end
                end
                if (state_next == DONE) done  <= 1'b1;
                if (state_next == ERR)  error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes go into a scoreboard
// queue as words are sent and are checked by a monitor when imem_we fires.
module tb_imem_loader;

    localparam int NLOC = 512;
    localparam int DB   = 32;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [8:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [9:0]  words_loaded;

    typedef struct packed {
        logic [31:0] cyc;
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc      = '0;
    logic        prev_we  = 1'b0;

    imem_loader #(.Nloc(NLOC), .Dbits(DB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the oldest scoreboard entry, address, data and cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            checks++;
            if (prev_we) begin
                failures++;
                $display("[TB] FAIL we_consecutive: imem_we high two cycles in a row at cycle %0d, required single-cycle strobe", cyc);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write: addr=%0d data=%h at cycle %0d, required no write", imem_waddr, imem_wdata, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (imem_waddr !== e.addr || imem_wdata !== e.data || cyc !== e.cyc) begin
                    failures++;
                    $display("[TB] FAIL write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             imem_waddr, imem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        prev_we = imem_we;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_write(input logic [8:0] addr, input logic [31:0] data);
        wr_t e;
        e.cyc  = cyc;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w, input bit is_data, input logic [8:0] addr);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
        end
        if (is_data) push_write(addr, w);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, error, words_loaded} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: rdy=%b we=%b addr=%0d data=%h hold=%b busy=%b done=%b err=%b wl=%0d, required all 0",
                     rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, error, words_loaded);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Nominal two-word load; a byte offered alongside load_start in IDLE must be ignored.
    task automatic test_nominal();
        load_start = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'hFF;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        checks++;
        if ({busy, cpu_hold, rx_ready, done} !== 4'b1110) begin
            failures++;
            $display("[TB] FAIL start_flags: busy/hold/ready/done=%b, required 1110", {busy, cpu_hold, rx_ready, done});
        end
        send_word(32'h0000_0002, 1'b0, 9'd0);
        send_word(32'h2008_0005, 1'b1, 9'd0);
        send_word(32'hAC08_0000, 1'b1, 9'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hCC10_0005, 1'b0, 9'd0);
`endif
        checks++;
        if ({done, error, cpu_hold, busy, words_loaded} !== {4'b1000, 10'd2}) begin
            failures++;
            $display("[TB] FAIL nominal_done: done=%b err=%b hold=%b busy=%b wl=%0d, required done=1 err=0 hold=0 busy=0 wl=2",
                     done, error, cpu_hold, busy, words_loaded);
        end
    endtask

    task automatic test_bad_length();
        logic [31:0] hdrs [2];
        hdrs[0] = 32'h0000_0000;
        hdrs[1] = 32'h0000_0201;
        for (int k = 0; k < 2; k++) begin
            start_load();
            send_word(hdrs[k], 1'b0, 9'd0);
            checks++;
            if ({error, cpu_hold, busy, done, rx_ready} !== 5'b11000) begin
                failures++;
                $display("[TB] FAIL bad_length_%0d: err/hold/busy/done/rdy=%b, required 11000", k, {error, cpu_hold, busy, done, rx_ready});
            end
        end
        start_load();
        send_word(32'h0000_0200, 1'b0, 9'd0);
        checks++;
        if ({busy, error, words_loaded} !== {2'b10, 10'd0}) begin
            failures++;
            $display("[TB] FAIL max_length_accepted: busy=%b err=%b wl=%0d, required busy=1 err=0 wl=0", busy, error, words_loaded);
        end
        apply_reset();
    endtask

    task automatic test_timeout();
        start_load();
        send_word(32'h0000_0002, 1'b0, 9'd0);
        send_byte(8'h12);
        repeat (TO - 1) @(posedge clk);
        #1;
        checks++;
        if ({busy, error} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL timeout_early: busy=%b err=%b after %0d idle cycles, required busy=1 err=0", busy, error, TO - 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({error, cpu_hold, busy, words_loaded} !== {3'b110, 10'd0}) begin
            failures++;
            $display("[TB] FAIL timeout_err: err=%b hold=%b busy=%b wl=%0d, required err=1 hold=1 busy=0 wl=0",
                     error, cpu_hold, busy, words_loaded);
        end
    endtask

    task automatic test_reset_midload();
        start_load();
        send_word(32'h0000_0002, 1'b0, 9'd0);
        send_word(32'hDEAD_BEEF, 1'b0, 9'd0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_pending_write: imem_we=%b during reset, required 0", imem_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, error, words_loaded} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_midload_outputs: rdy=%b we=%b addr=%0d data=%h hold=%b busy=%b wl=%0d, required all 0",
                     rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, words_loaded);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignored_restart();
        start_load();
        send_word(32'h0000_0002, 1'b0, 9'd0);
        send_word(32'h1111_2222, 1'b1, 9'd0);
        send_byte(8'h33);
        send_byte(8'h34);
        load_start = 1'b1;
        send_byte(8'h35);
        load_start = 1'b0;
        checks++;
        if ({busy, done, error, words_loaded} !== {3'b100, 10'd1}) begin
            failures++;
            $display("[TB] FAIL restart_ignored: busy=%b done=%b err=%b wl=%0d, required busy=1 done=0 err=0 wl=1",
                     busy, done, error, words_loaded);
        end
        send_byte(8'h36);
        push_write(9'd1, 32'h3334_3536);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h1111_2222 + 32'h3334_3536, 1'b0, 9'd0);
`endif
        checks++;
        if ({done, cpu_hold, words_loaded} !== {2'b10, 10'd2}) begin
            failures++;
            $display("[TB] FAIL restart_complete: done=%b hold=%b wl=%0d, required done=1 hold=0 wl=2", done, cpu_hold, words_loaded);
        end
    endtask

    // Random five-word load with one short source bubble, well inside the watchdog window.
    task automatic test_back_to_back();
        logic [31:0] w;
        logic [31:0] sum;
        sum = '0;
        start_load();
        send_word(32'd5, 1'b0, 9'd0);
        for (int i = 0; i < 5; i++) begin
            w   = $urandom;
            sum = sum + w;
            send_word(w, 1'b1, 9'(i));
            if (i == 2) repeat (3) @(posedge clk);
            if (i == 2) #1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum, 1'b0, 9'd0);
`endif
        checks++;
        if ({done, error, words_loaded} !== {2'b10, 10'd5}) begin
            failures++;
            $display("[TB] FAIL b2b_done: done=%b err=%b wl=%0d, required done=1 err=0 wl=5 (sum %h)", done, error, words_loaded, sum);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_csum_mismatch();
        start_load();
        send_word(32'd1, 1'b0, 9'd0);
        send_word(32'd1, 1'b1, 9'd0);
        send_word(32'd2, 1'b0, 9'd0);
        checks++;
        if ({error, cpu_hold, done} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL csum_mismatch: err=%b hold=%b done=%b, required err=1 hold=1 done=0", error, cpu_hold, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_bad_length();
        test_timeout();
        test_reset_midload();
        test_ignored_restart();
        test_back_to_back();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_csum_mismatch();
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL missing_writes: %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
